// File: rtl/sdram_arb_pkg.sv
// Shared types and default constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_STARVE_MAX = 8;
  localparam int DEF_TIMEOUT    = 255;

  // Data returned to the tape port when a read is abandoned.
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4
  } arb_state_t;

  // Loader FIFO entry layout: address in the upper bits, data in the low byte.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/arb_wr_fifo.sv
// Loader write FIFO. Pointers carry one extra wrap bit so full and empty are
// distinguishable; full is reported from pre-pop occupancy, but a push is still
// taken in a cycle where a pop frees the slot.
module arb_wr_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      level_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Occupancy flags and the qualified push/pop strobes.
  always_comb begin
    level_s   = wr_ptr_r - rd_ptr_r;
    full      = (level_s == (AW + 1)'(DEPTH));
    empty     = (level_s == '0);
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  assign head_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates a buffered loader write stream and single outstanding tape reads
// onto one SDRAM controller port, with a starvation guard for the tape side
// and a timeout on every memory access.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              CLK50MHZ,
  input  logic              COCO_RESET_N,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_full,
  input  logic              tp_rd,
  input  logic [ADDR_W-1:0] tp_addr,
  output logic              tp_valid,
  output logic [DATA_W-1:0] tp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ready,
  output logic              err_timeout
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  arb_state_t         state_r;
  logic               tp_pending_r;
  logic [ADDR_W-1:0]  tp_addr_r;
  logic [SW-1:0]      starve_r;
  logic [WW-1:0]      wait_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_din_r;
  logic               mem_we_r;
  logic               mem_rd_r;
  logic               tp_valid_r;
  logic [DATA_W-1:0]  tp_data_r;
  logic               err_timeout_r;

  logic [ENTRY_W-1:0] fifo_in_s;
  logic [ENTRY_W-1:0] fifo_head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               fifo_pop_s;
  logic               wr_grant_s;
  logic               rd_grant_s;
  logic               wait_state_s;
  logic               expire_s;
  logic               finish_s;
  logic               rd_done_s;

  assign fifo_in_s = pack_entry(ld_addr, ld_data);

  arb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk       (CLK50MHZ),
    .rst_n     (COCO_RESET_N),
    .push      (ld_wr),
    .pop       (fifo_pop_s),
    .wr_data   (fifo_in_s),
    .head_data (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign ld_full     = fifo_full_s;
  assign mem_addr    = mem_addr_r;
  assign mem_din     = mem_din_r;
  assign mem_we      = mem_we_r;
  assign mem_rd      = mem_rd_r;
  assign tp_valid    = tp_valid_r;
  assign tp_data     = tp_data_r;
  assign err_timeout = err_timeout_r;

  // Grant decision in IDLE and completion/timeout decode in the wait states.
  always_comb begin
    wr_grant_s   = 1'b0;
    rd_grant_s   = 1'b0;
    wait_state_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && (starve_r < STARVE_LIM)) begin
          wr_grant_s = 1'b1;
        end else if (tp_pending_r) begin
          rd_grant_s = 1'b1;
        end else begin
          wr_grant_s = 1'b0;
          rd_grant_s = 1'b0;
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        wait_state_s = 1'b1;
      end
      default: begin
        wait_state_s = 1'b0;
      end
    endcase
    expire_s   = wait_state_s && !mem_ready && (wait_r == WAIT_LAST);
    finish_s   = wait_state_s && (mem_ready || expire_s);
    fifo_pop_s = finish_s && (state_r == ST_WR_WAIT);
    rd_done_s  = finish_s && (state_r == ST_RD_WAIT);
  end

  // Tape request latch: one outstanding read, later strobes ignored until done.
  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      tp_pending_r <= 1'b0;
      tp_addr_r    <= '0;
    end else if (rd_done_s) begin
      tp_pending_r <= 1'b0;
    end else if (tp_rd && !tp_pending_r) begin
      tp_pending_r <= 1'b1;
      tp_addr_r    <= tp_addr;
    end
  end

  // Starvation counter: counts writes granted while a tape read waits.
  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      starve_r <= '0;
    end else if (!tp_pending_r || rd_grant_s) begin
      starve_r <= '0;
    end else if (wr_grant_s && (starve_r < STARVE_LIM)) begin
      starve_r <= starve_r + SW'(1);
    end
  end

  // Arbiter FSM with registered memory-side and tape-side outputs.
  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      state_r       <= ST_IDLE;
      wait_r        <= '0;
      mem_addr_r    <= '0;
      mem_din_r     <= '0;
      mem_we_r      <= 1'b0;
      mem_rd_r      <= 1'b0;
      tp_valid_r    <= 1'b0;
      tp_data_r     <= '0;
      err_timeout_r <= 1'b0;
    end else begin
      mem_we_r   <= 1'b0;
      mem_rd_r   <= 1'b0;
      tp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          wait_r <= '0;
          if (wr_grant_s) begin
            state_r    <= ST_WR_ISSUE;
            mem_we_r   <= 1'b1;
            mem_addr_r <= fifo_head_s[ENTRY_W-1:DATA_W];
            mem_din_r  <= fifo_head_s[DATA_W-1:0];
          end else if (rd_grant_s) begin
            state_r    <= ST_RD_ISSUE;
            mem_rd_r   <= 1'b1;
            mem_addr_r <= tp_addr_r;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR_ISSUE: begin
          state_r <= ST_WR_WAIT;
          wait_r  <= '0;
        end
        ST_RD_ISSUE: begin
          state_r <= ST_RD_WAIT;
          wait_r  <= '0;
        end
        ST_WR_WAIT: begin
          if (finish_s) begin
            state_r <= ST_IDLE;
            wait_r  <= '0;
            if (expire_s) begin
              err_timeout_r <= 1'b1;
            end
          end else begin
            wait_r <= wait_r + WW'(1);
          end
        end
        ST_RD_WAIT: begin
          if (mem_ready) begin
            state_r    <= ST_IDLE;
            wait_r     <= '0;
            tp_data_r  <= mem_dout;
            tp_valid_r <= 1'b1;
          end else if (expire_s) begin
            state_r       <= ST_IDLE;
            wait_r        <= '0;
            tp_data_r     <= TIMEOUT_DATA;
            tp_valid_r    <= 1'b1;
            err_timeout_r <= 1'b1;
          end else begin
            wait_r <= wait_r + WW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          wait_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: table-driven single accesses plus
// hand-written sequences for full FIFO, push/pop overlap, starvation, timeout
// and reset during an access. Expected writes/reads go into scoreboard queues
// when stimulus is driven and are compared when the DUT pulses mem_we, mem_rd
// or tp_valid.
module tb_sdram_port_arbiter;

  logic        CLK50MHZ = 1'b0;
  logic        COCO_RESET_N;
  logic        ld_wr;
  logic [24:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_full;
  logic        tp_rd;
  logic [24:0] tp_addr;
  logic        tp_valid;
  logic [7:0]  tp_data;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        mem_ready;
  logic        err_timeout;

  logic        resp_ready;
  logic        man_ready;
  logic [7:0]  dout_val;

  assign mem_ready = resp_ready | man_ready;
  assign mem_dout  = dout_val;

  sdram_port_arbiter dut (
    .CLK50MHZ     (CLK50MHZ),
    .COCO_RESET_N (COCO_RESET_N),
    .ld_wr        (ld_wr),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_full      (ld_full),
    .tp_rd        (tp_rd),
    .tp_addr      (tp_addr),
    .tp_valid     (tp_valid),
    .tp_data      (tp_data),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_rd       (mem_rd),
    .mem_dout     (mem_dout),
    .mem_ready    (mem_ready),
    .err_timeout  (err_timeout)
  );

  initial forever #10 CLK50MHZ = ~CLK50MHZ;

  typedef struct {
    bit          is_rd;
    logic [24:0] addr;
    logic [7:0]  data;
    int          lat;
    logic [24:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t        vecs [6];
  logic [32:0] wr_q [$];
  logic [24:0] rda_q [$];
  logic [7:0]  rdd_q [$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_we    = 0;
  int   n_valid = 0;
  int   we_at_rd = 0;
  int   resp_cnt = 0;
  int   lat = 2;
  bit   auto_en = 1'b1;
  logic prev_we = 1'b0;
  logic prev_rd = 1'b0;
  logic prev_valid = 1'b0;
  logic [32:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: wait for the falling edge, score DUT outputs, run the memory responder.
  task automatic step();
    @(negedge CLK50MHZ);
    if (COCO_RESET_N) begin
      if (mem_we) begin
        n_we++;
        check("we_pulse_width", prev_we, 1'b0);
        check("we_expected", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          check("we_addr", mem_addr, mon_e[32:8]);
          check("we_data", mem_din, mon_e[7:0]);
        end
      end
      if (mem_rd) begin
        we_at_rd = n_we;
        check("rd_pulse_width", prev_rd, 1'b0);
        check("rd_expected", rda_q.size() != 0, 1'b1);
        if (rda_q.size() != 0) check("rd_addr", mem_addr, rda_q.pop_front());
      end
      if (tp_valid) begin
        n_valid++;
        check("valid_pulse_width", prev_valid, 1'b0);
        check("valid_expected", rdd_q.size() != 0, 1'b1);
        if (rdd_q.size() != 0) check("tp_data", tp_data, rdd_q.pop_front());
      end
    end
    prev_we    = mem_we;
    prev_rd    = mem_rd;
    prev_valid = tp_valid;
    resp_ready = 1'b0;
    if (!COCO_RESET_N) begin
      resp_cnt = 0;
    end else if (auto_en && (mem_we || mem_rd)) begin
      resp_cnt = lat;
    end else if (resp_cnt == 1) begin
      resp_ready = 1'b1;
      resp_cnt   = 0;
    end else if (resp_cnt > 1) begin
      resp_cnt--;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((wr_q.size() != 0 || rda_q.size() != 0 || rdd_q.size() != 0) && k < 1000) begin
      step();
      k++;
    end
    check({name, "_drain"}, k < 1000, 1'b1);
    tick(8);
  endtask

  task automatic push_wr(input logic [24:0] a, input logic [7:0] d, input bit accepted);
    ld_wr   = 1'b1;
    ld_addr = a;
    ld_data = d;
    if (accepted) wr_q.push_back({a, d});
    step();
    ld_wr = 1'b0;
  endtask

  task automatic issue_rd(input logic [24:0] a);
    tp_rd   = 1'b1;
    tp_addr = a;
    step();
    tp_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int we0;
    int v0;
    int k;
    int cnt;

    vecs[0] = '{1'b0, 25'h0000010, 8'hA5, 3, 25'h0000010, 8'hA5};
    vecs[1] = '{1'b0, 25'h1FFFFFF, 8'h00, 1, 25'h1FFFFFF, 8'h00};
    vecs[2] = '{1'b0, 25'h0000000, 8'hFF, 4, 25'h0000000, 8'hFF};
    vecs[3] = '{1'b1, 25'h0ABCDEF, 8'h5A, 2, 25'h0ABCDEF, 8'h5A};
    vecs[4] = '{1'b1, 25'h1FFFFFF, 8'hC3, 1, 25'h1FFFFFF, 8'hC3};
    vecs[5] = '{1'b0, 25'h1555555, 8'h3C, 2, 25'h1555555, 8'h3C};

    COCO_RESET_N = 1'b0;
    ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    tp_rd = 1'b0; tp_addr = '0;
    man_ready = 1'b0; resp_ready = 1'b0; dout_val = 8'h00;

    // Reset state
    tick(3);
    check("reset_outputs",
          {ld_full, tp_valid, tp_data, mem_addr, mem_din, mem_we, mem_rd, err_timeout}, 64'd0);
    COCO_RESET_N = 1'b1;
    tick(2);

    // Table-driven single accesses
    for (int i = 0; i < 6; i++) begin
      lat = vecs[i].lat;
      we0 = n_we;
      v0  = n_valid;
      if (vecs[i].is_rd) begin
        dout_val = vecs[i].data;
        rda_q.push_back(vecs[i].exp_addr);
        rdd_q.push_back(vecs[i].exp_data);
        issue_rd(vecs[i].addr);
      end else begin
        ld_wr   = 1'b1;
        ld_addr = vecs[i].addr;
        ld_data = vecs[i].data;
        wr_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
        step();
        ld_wr = 1'b0;
      end
      wait_drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_we_count", i), n_we - we0, vecs[i].is_rd ? 0 : 1);
      check($sformatf("vec%0d_valid_count", i), n_valid - v0, vecs[i].is_rd ? 1 : 0);
      check($sformatf("vec%0d_full_after", i), ld_full, 1'b0);
    end

    // Full FIFO: five back-to-back writes with mem_ready held off
    auto_en = 1'b0;
    we0 = n_we;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_before_push%0d", i), ld_full, i >= 4);
      push_wr(25'h0000200 + 25'(i), 8'h10 + 8'(i), i < 4);
    end
    check("full_after_push4", ld_full, 1'b1);
    check("full_we_while_held", n_we - we0, 1);
    tick(5);
    auto_en = 1'b1;
    lat = 2;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    wait_drain("full");
    check("full_we_total", n_we - we0, 4);
    check("full_empty_after", ld_full, 1'b0);

    // Simultaneous push and pop on a full FIFO
    auto_en = 1'b0;
    we0 = n_we;
    for (int i = 0; i < 4; i++) push_wr(25'h0000400 + 25'(i), 8'hB0 + 8'(i), 1'b1);
    check("sim_full_before", ld_full, 1'b1);
    auto_en   = 1'b1;
    lat       = 1;
    man_ready = 1'b1;
    push_wr(25'h0000404, 8'hB4, 1'b1);
    man_ready = 1'b0;
    check("sim_full_after", ld_full, 1'b1);
    wait_drain("sim");
    check("sim_we_total", n_we - we0, 5);

    // Starvation guard: loader keeps the FIFO busy while a tape read waits
    auto_en  = 1'b1;
    lat      = 2;
    dout_val = 8'h3C;
    rda_q.push_back(25'h0100000);
    rdd_q.push_back(8'h3C);
    we0 = n_we;
    v0  = n_valid;
    k   = 0;
    cnt = 0;
    tp_rd   = 1'b1;
    tp_addr = 25'h0100000;
    while (n_valid == v0 && k < 2000) begin
      if (!ld_full) begin
        ld_wr   = 1'b1;
        ld_addr = 25'h0000300 + 25'(cnt);
        ld_data = 8'(cnt) ^ 8'h5A;
        wr_q.push_back({ld_addr, ld_data});
        cnt++;
      end else begin
        ld_wr = 1'b0;
      end
      step();
      tp_rd = 1'b0;
      k++;
    end
    ld_wr = 1'b0;
    check("starve_read_done", k < 2000, 1'b1);
    check("starve_writes_before_read", we_at_rd - we0, 8);
    wait_drain("starve");

    // Timeout on a tape read
    auto_en  = 1'b0;
    dout_val = 8'h77;
    rda_q.push_back(25'h0000200);
    rdd_q.push_back(8'hFF);
    check("to_err_before", err_timeout, 1'b0);
    issue_rd(25'h0000200);
    k = 0;
    while (!mem_rd && k < 20) begin
      step();
      k++;
    end
    check("to_rd_seen", mem_rd, 1'b1);
    k = 0;
    while (!tp_valid && k < 400) begin
      step();
      k++;
    end
    check("to_latency", k, 256);
    check("to_err_set", err_timeout, 1'b1);
    auto_en = 1'b1;
    lat = 2;
    tick(2);
    push_wr(25'h0000555, 8'h99, 1'b1);
    wait_drain("to_after");
    check("to_err_sticky", err_timeout, 1'b1);

    // Reset in the middle of a read
    auto_en = 1'b0;
    v0 = n_valid;
    rda_q.push_back(25'h0000ABC);
    issue_rd(25'h0000ABC);
    k = 0;
    while (!mem_rd && k < 20) begin
      step();
      k++;
    end
    check("rst_rd_seen", mem_rd, 1'b1);
    tick(3);
    COCO_RESET_N = 1'b0;
    #1;
    check("rst_async_outputs",
          {ld_full, tp_valid, tp_data, mem_addr, mem_din, mem_we, mem_rd, err_timeout}, 64'd0);
    step();
    COCO_RESET_N = 1'b1;
    step();
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    tick(6);
    check("rst_no_late_valid", n_valid - v0, 0);
    check("rst_queues_clear", rda_q.size() + wr_q.size() + rdd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
